// File: rtl/jk_mod_counter_pkg.sv
// Shared JK excitation encoding and the helper that derives a J/K pair
// from a present/next bit pair.
package jk_mod_counter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  // {J,K}: set on 0->1, clear on 1->0, hold otherwise; never produces toggle.
  function automatic jk_op_e jk_excite(input logic q_bit, input logic next_bit);
    jk_op_e op;
    op = JK_HOLD;
    if (!q_bit && next_bit) op = JK_SET;
    else if (q_bit && !next_bit) op = JK_CLR;
    return op;
  endfunction

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// Single JK flip-flop storage cell with asynchronous active-low reset to q=0.
module jk_cell
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      case (jk_op_e'({j, k}))
        JK_HOLD: q_q <= q_q;
        JK_CLR:  q_q <= 1'b0;
        JK_SET:  q_q <= 1'b1;
        JK_TGL:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-N counter whose state lives in JK cells; this level computes
// the next state, the per-bit J/K excitation, terminal count and pulses.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the range check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             din_ok;
  logic             at_max;
  logic             at_zero;
  logic             wrap_q;
  logic             load_err_q;

  assign din_ok  = {1'b0, din} < MOD_EXT;
  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);
  assign tc      = en & ~load & ((up & at_max) | (~up & at_zero));

  always_comb begin
    next_d = q;
    if (load) begin
      next_d = din_ok ? din : '0;
    end else if (en) begin
      if (up) next_d = at_max ? '0 : q + WIDTH'(1);
      else    next_d = at_zero ? MAX_VAL : q - WIDTH'(1);
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      logic [1:0] op;
      op   = jk_excite(q[i], next_d[i]);
      j[i] = op[1];
      k[i] = op[0];
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[gi]),
      .k     (k[gi]),
      .q     (q[gi]),
      .qb    (qb[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= tc;
      load_err_q <= load & ~din_ok;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         tc;
  logic         wrap;
  logic         load_err;

  typedef struct packed {
    logic [W-1:0] q;
    logic         wrap;
    logic         lerr;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mq = '0;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .q        (q),
    .qb       (qb),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one operation, check tc before the edge, then compare after the edge.
  task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] d);
    logic  exp_tc;
    exp_t  ex;
    exp_t  got;
    en = e; up = u; load = l; din = d;
    #1;
    exp_tc = e & ~l & ((u & (mq == 4'(M - 1))) | (~u & (mq == 4'd0)));
    check("tc", {31'd0, tc}, {31'd0, exp_tc});
    ex.wrap = exp_tc;
    ex.lerr = 1'b0;
    if (l) begin
      if (32'(d) < M) ex.q = d;
      else begin ex.q = '0; ex.lerr = 1'b1; end
    end else if (e && u) ex.q = (mq == 4'(M - 1)) ? 4'd0 : mq + 4'd1;
    else if (e)          ex.q = (mq == 4'd0) ? 4'(M - 1) : mq - 4'd1;
    else                 ex.q = mq;
    mq = ex.q;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      check("q", {28'd0, q}, {28'd0, got.q});
      check("qb", {28'd0, qb}, {28'd0, ~got.q});
      check("wrap", {31'd0, wrap}, {31'd0, got.wrap});
      check("load_err", {31'd0, load_err}, {31'd0, got.lerr});
    end
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    mq = '0;
    check({tag, "_q"}, {28'd0, q}, 32'd0);
    check({tag, "_qb"}, {28'd0, qb}, 32'hF);
    check({tag, "_wrap"}, {31'd0, wrap}, 32'd0);
    check({tag, "_lerr"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset held across several edges.
    #2;
    reset_check("por");
    #20;
    reset_check("por_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #2;

    // Count up 12 edges: 0..9, 0, 1 with a single wrap.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);

    // From reset, count down: 0 -> 9 -> 8.
    reset_check("rst_dn");
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Load with en: load wins, no tc/wrap; then 8, 9, 0 with wrap.
    step(1'b1, 1'b1, 1'b1, 4'd7);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Out-of-range loads and boundary loads.
    step(1'b0, 1'b1, 1'b1, 4'd12);
    step(1'b0, 1'b1, 1'b1, 4'd3);
    step(1'b1, 1'b1, 1'b1, 4'd10);
    step(1'b1, 1'b0, 1'b1, 4'd15);
    step(1'b1, 1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Hold at 5 while toggling direction.
    step(1'b0, 1'b1, 1'b1, 4'd5);
    for (int i = 0; i < 4; i++) step(1'b0, 1'(i), 1'b0, '0);

    // Direction change on consecutive edges.
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Async reset at q=9 between edges, then one up edge.
    step(1'b0, 1'b1, 1'b1, 4'd9);
    reset_check("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    step(1'b1, 1'b1, 1'b0, '0);

    // Reset while a wrap pulse is active cancels it.
    step(1'b0, 1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b1, 1'b0, '0);
    reset_check("rst_wrap");
    @(negedge clk);
    rst_n = 1'b1;
    #2;

    // Reset while a load_err pulse is active cancels it.
    step(1'b0, 1'b1, 1'b1, 4'd11);
    reset_check("rst_lerr");
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    step(1'b1, 1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
